// File: rtl/matrix_cursor_ctrl.sv
// matrix_cursor_ctrl: cursor and pixel-edit controller for an LED matrix.
// Takes debounced one-cycle button pulses, moves a blinking cursor, and
// issues frame-buffer writes over a req/ack port. A select toggles the
// pixel under the cursor. A clear sweeps the whole frame writing zeros.

module matrix_cursor_ctrl #(
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    parameter int ROW_W     = 3,
    parameter int COL_W     = 3,
    parameter int BLINK_DIV = 12500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_up_p,
    input  logic             btn_dn_p,
    input  logic             btn_lt_p,
    input  logic             btn_rt_p,
    input  logic             btn_sel_p,
    input  logic             btn_clr_p,
    input  logic             pix_q,
    input  logic             wr_ack,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col,
    output logic             cursor_blink,
    output logic             wr_req,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic             wr_data,
    output logic             busy
);

    // Blink counter width covers 0..BLINK_DIV-1.
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [BW-1:0]    BLINK_ONE  = BW'(1);

    logic [1:0]       state;
    logic [BW-1:0]    blink_cnt;

    logic [ROW_W-1:0] row_up;
    logic [ROW_W-1:0] row_dn;
    logic [COL_W-1:0] col_lt;
    logic [COL_W-1:0] col_rt;
    logic [ROW_W-1:0] row_next;
    logic [COL_W-1:0] col_next;
    logic             in_idle;
    logic             move_req;
    logic             move_eff;
    logic             ack_fire;
    logic             clr_last;
    logic             clear_done;

    // Wrapped neighbour positions of the cursor in each direction.
    always_comb begin
        row_up = (cur_row == '0)      ? ROW_LAST : (cur_row - ROW_ONE);
        row_dn = (cur_row == ROW_LAST) ? '0      : (cur_row + ROW_ONE);
        col_lt = (cur_col == '0)      ? COL_LAST : (cur_col - COL_ONE);
        col_rt = (cur_col == COL_LAST) ? '0      : (cur_col + COL_ONE);
    end

    // Row and column are resolved independently; opposing presses cancel.
    always_comb begin
        row_next = cur_row;
        col_next = cur_col;
        case ({btn_up_p, btn_dn_p})
            2'b10:   row_next = row_up;
            2'b01:   row_next = row_dn;
            default: row_next = cur_row;
        endcase
        case ({btn_lt_p, btn_rt_p})
            2'b10:   col_next = col_lt;
            2'b01:   col_next = col_rt;
            default: col_next = cur_col;
        endcase
    end

    // Event qualification: moves only count in IDLE with no clear/select,
    // and only when the position really changes (cancelled presses do not
    // restart the blink phase).
    always_comb begin
        in_idle    = (state == ST_IDLE);
        move_req   = in_idle && !btn_clr_p && !btn_sel_p;
        move_eff   = move_req && ((row_next != cur_row) || (col_next != cur_col));
        ack_fire   = wr_req && wr_ack;
        clr_last   = (wr_row == ROW_LAST) && (wr_col == COL_LAST);
        clear_done = (state == ST_CLEAR) && ack_fire && clr_last;
    end

    // Control FSM: cursor position, write port and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cur_row <= '0;
            cur_col <= '0;
            wr_req  <= 1'b0;
            wr_row  <= '0;
            wr_col  <= '0;
            wr_data <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (btn_clr_p) begin
                        state   <= ST_CLEAR;
                        wr_req  <= 1'b1;
                        wr_row  <= '0;
                        wr_col  <= '0;
                        wr_data <= 1'b0;
                        busy    <= 1'b1;
                    end else if (btn_sel_p) begin
                        state   <= ST_WRITE;
                        wr_req  <= 1'b1;
                        wr_row  <= cur_row;
                        wr_col  <= cur_col;
                        wr_data <= ~pix_q;
                        busy    <= 1'b1;
                    end else begin
                        cur_row <= row_next;
                        cur_col <= col_next;
                    end
                end
                ST_WRITE: begin
                    if (ack_fire) begin
                        state  <= ST_IDLE;
                        wr_req <= 1'b0;
                        busy   <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (ack_fire) begin
                        if (clr_last) begin
                            state   <= ST_IDLE;
                            wr_req  <= 1'b0;
                            busy    <= 1'b0;
                            cur_row <= '0;
                            cur_col <= '0;
                        end else if (wr_col == COL_LAST) begin
                            wr_col <= '0;
                            wr_row <= wr_row + ROW_ONE;
                        end else begin
                            wr_col <= wr_col + COL_ONE;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    wr_req <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

    // Blink phase generator; restarts visible after a move or a finished clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt    <= '0;
            cursor_blink <= 1'b1;
        end else if (move_eff) begin
            blink_cnt    <= '0;
            cursor_blink <= 1'b1;
        end else begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt    <= '0;
                cursor_blink <= clear_done ? 1'b1 : ~cursor_blink;
            end else begin
                blink_cnt    <= blink_cnt + BLINK_ONE;
                cursor_blink <= clear_done ? 1'b1 : cursor_blink;
            end
        end
    end

endmodule

// File: tb/tb_matrix_cursor_ctrl.sv
// Directed self-checking bench for matrix_cursor_ctrl (8x8, BLINK_DIV=4).
// Inputs change and outputs are sampled 1 time unit after the rising edge.

module tb_matrix_cursor_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_up_p, btn_dn_p, btn_lt_p, btn_rt_p, btn_sel_p, btn_clr_p;
    logic       pix_q;
    logic       wr_ack;
    logic [2:0] cur_row, cur_col, wr_row, wr_col;
    logic       cursor_blink, wr_req, wr_data, busy;

    int checks;
    int failures;

    matrix_cursor_ctrl #(
        .ROWS(8), .COLS(8), .ROW_W(3), .COL_W(3), .BLINK_DIV(4)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_up_p(btn_up_p), .btn_dn_p(btn_dn_p),
        .btn_lt_p(btn_lt_p), .btn_rt_p(btn_rt_p),
        .btn_sel_p(btn_sel_p), .btn_clr_p(btn_clr_p),
        .pix_q(pix_q), .wr_ack(wr_ack),
        .cur_row(cur_row), .cur_col(cur_col), .cursor_blink(cursor_blink),
        .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle button pulse pattern, then release all buttons.
    task automatic pulse(input logic up, input logic dn, input logic lt,
                         input logic rt, input logic sel, input logic clr);
        btn_up_p = up; btn_dn_p = dn; btn_lt_p = lt;
        btn_rt_p = rt; btn_sel_p = sel; btn_clr_p = clr;
        step();
        btn_up_p = 0; btn_dn_p = 0; btn_lt_p = 0;
        btn_rt_p = 0; btn_sel_p = 0; btn_clr_p = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        btn_dn_p = 1; btn_rt_p = 1; wr_ack = 1;
        rst = 1'b1;
        step();
        step();
        btn_dn_p = 0; btn_rt_p = 0; wr_ack = 0;
        rst = 1'b0;
        checks++; if (cur_row !== 3'd0) begin failures++; $display("[TB] FAIL reset_row: got %0d expected 0", cur_row); end
        checks++; if (cur_col !== 3'd0) begin failures++; $display("[TB] FAIL reset_col: got %0d expected 0", cur_col); end
        checks++; if (wr_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_wr_req: got %0b expected 0", wr_req); end
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (cursor_blink !== 1'b1) begin failures++; $display("[TB] FAIL reset_blink: got %0b expected 1", cursor_blink); end
        checks++; if ({wr_row, wr_col, wr_data} !== 7'd0) begin failures++; $display("[TB] FAIL reset_wr_bus: got %0d/%0d/%0b expected 0/0/0", wr_row, wr_col, wr_data); end
    endtask

    task automatic test_move();
        logic [2:0] exp_row [5];
        logic [2:0] exp_col [5];
        exp_row = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
        exp_col = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd6};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            // Let the blink counter advance between moves so a reset of it matters.
            step(); step();
            if (i < 3) pulse(0, 1, 0, 0, 0, 0);
            else       pulse(0, 0, 1, 0, 0, 0);
            checks++; if (cur_row !== exp_row[i] || cur_col !== exp_col[i]) begin
                failures++; $display("[TB] FAIL move_pos[%0d]: got (%0d,%0d) expected (%0d,%0d)", i, cur_row, cur_col, exp_row[i], exp_col[i]);
            end
            checks++; if (cursor_blink !== 1'b1) begin
                failures++; $display("[TB] FAIL move_blink[%0d]: got %0b expected 1", i, cursor_blink);
            end
        end
    endtask

    task automatic test_move_combo();
        do_reset();
        pulse(1, 1, 1, 0, 0, 0);
        checks++; if (cur_row !== 3'd0 || cur_col !== 3'd7) begin
            failures++; $display("[TB] FAIL combo_updn_lt: got (%0d,%0d) expected (0,7)", cur_row, cur_col);
        end
        pulse(0, 0, 0, 1, 0, 0);
        checks++; if (cur_row !== 3'd0 || cur_col !== 3'd0) begin
            failures++; $display("[TB] FAIL combo_rt_wrap: got (%0d,%0d) expected (0,0)", cur_row, cur_col);
        end
        pulse(1, 0, 0, 0, 0, 0);
        checks++; if (cur_row !== 3'd7) begin
            failures++; $display("[TB] FAIL combo_up_wrap: got %0d expected 7", cur_row);
        end
        pulse(0, 1, 1, 1, 0, 0);
        checks++; if (cur_row !== 3'd0 || cur_col !== 3'd0) begin
            failures++; $display("[TB] FAIL combo_dn_wrap_ltrt: got (%0d,%0d) expected (0,0)", cur_row, cur_col);
        end
    endtask

    task automatic test_select();
        do_reset();
        pulse(0, 1, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        pulse(0, 0, 1, 0, 0, 0);
        checks++; if (cur_row !== 3'd2 || cur_col !== 3'd5) begin
            failures++; $display("[TB] FAIL sel_setup: got (%0d,%0d) expected (2,5)", cur_row, cur_col);
        end
        pix_q = 1'b0;
        wr_ack = 1'b0;
        pulse(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            checks++; if (wr_req !== 1'b1 || wr_row !== 3'd2 || wr_col !== 3'd5 || wr_data !== 1'b1 || busy !== 1'b1) begin
                failures++; $display("[TB] FAIL sel_hold[%0d]: got req=%0b (%0d,%0d,%0b) busy=%0b expected req=1 (2,5,1) busy=1", i, wr_req, wr_row, wr_col, wr_data, busy);
            end
            wr_ack = (i == 4);
            btn_dn_p = (i == 1);
            step();
            wr_ack = 1'b0;
            btn_dn_p = 1'b0;
        end
        checks++; if (wr_req !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL sel_done: got req=%0b busy=%0b expected req=0 busy=0", wr_req, busy);
        end
        checks++; if (cur_row !== 3'd2 || cur_col !== 3'd5) begin
            failures++; $display("[TB] FAIL sel_drop_move: got (%0d,%0d) expected (2,5)", cur_row, cur_col);
        end
        // A stray ack while idle must not start anything.
        wr_ack = 1'b1;
        step();
        wr_ack = 1'b0;
        checks++; if (wr_req !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL sel_stray_ack: got req=%0b busy=%0b expected 0/0", wr_req, busy);
        end
    endtask

    task automatic test_clear();
        int bad;
        bad = 0;
        wr_ack = 1'b1;
        pulse(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 64; k++) begin
            checks++; if (wr_req !== 1'b1 || busy !== 1'b1 || wr_data !== 1'b0 ||
                          wr_row !== 3'(k / 8) || wr_col !== 3'(k % 8)) begin
                failures++; bad++;
                if (bad < 5) $display("[TB] FAIL clear_seq[%0d]: got req=%0b busy=%0b (%0d,%0d,%0b) expected req=1 busy=1 (%0d,%0d,0)", k, wr_req, busy, wr_row, wr_col, wr_data, k / 8, k % 8);
            end
            step();
        end
        wr_ack = 1'b0;
        checks++; if (wr_req !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL clear_end: got req=%0b busy=%0b expected 0/0", wr_req, busy);
        end
        checks++; if (cur_row !== 3'd0 || cur_col !== 3'd0 || cursor_blink !== 1'b1) begin
            failures++; $display("[TB] FAIL clear_cursor: got (%0d,%0d) blink=%0b expected (0,0) blink=1", cur_row, cur_col, cursor_blink);
        end
    endtask

    task automatic test_back_to_back_clr_sel();
        int cyc;
        do_reset();
        pulse(0, 1, 0, 1, 0, 0);
        pix_q = 1'b0;
        wr_ack = 1'b0;
        pulse(0, 0, 0, 0, 1, 1);
        checks++; if (wr_req !== 1'b1 || wr_row !== 3'd0 || wr_col !== 3'd0 || wr_data !== 1'b0) begin
            failures++; $display("[TB] FAIL clrsel_first: got req=%0b (%0d,%0d,%0b) expected req=1 (0,0,0)", wr_req, wr_row, wr_col, wr_data);
        end
        wr_ack = 1'b1;
        step();
        checks++; if (wr_row !== 3'd0 || wr_col !== 3'd1) begin
            failures++; $display("[TB] FAIL clrsel_advance: got (%0d,%0d) expected (0,1)", wr_row, wr_col);
        end
        cyc = 1;
        while (busy === 1'b1 && cyc < 100) begin
            step();
            cyc++;
        end
        wr_ack = 1'b0;
        checks++; if (cyc !== 64) begin
            failures++; $display("[TB] FAIL clrsel_length: got %0d expected 64", cyc);
        end
    endtask

    task automatic test_blink();
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            step();
            checks++; if (cursor_blink !== (((n / 4) % 2) == 0)) begin
                failures++; $display("[TB] FAIL blink[%0d]: got %0b expected %0b", n, cursor_blink, ((n / 4) % 2) == 0);
            end
        end
    endtask

    task automatic test_rst_abort();
        do_reset();
        wr_ack = 1'b1;
        pulse(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 10; k++) step();
        checks++; if (wr_row !== 3'd1 || wr_col !== 3'd2 || wr_req !== 1'b1) begin
            failures++; $display("[TB] FAIL abort_addr: got req=%0b (%0d,%0d) expected req=1 (1,2)", wr_req, wr_row, wr_col);
        end
        wr_ack = 1'b0;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (wr_req !== 1'b0 || busy !== 1'b0 || cur_row !== 3'd0 || cur_col !== 3'd0 || cursor_blink !== 1'b1) begin
            failures++; $display("[TB] FAIL abort_reset: got req=%0b busy=%0b (%0d,%0d) blink=%0b expected 0 0 (0,0) 1", wr_req, busy, cur_row, cur_col, cursor_blink);
        end
        step();
        checks++; if (wr_req !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("[TB] FAIL abort_stays_idle: got req=%0b busy=%0b expected 0/0", wr_req, busy);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        btn_up_p = 0; btn_dn_p = 0; btn_lt_p = 0;
        btn_rt_p = 0; btn_sel_p = 0; btn_clr_p = 0;
        pix_q = 1'b0;
        wr_ack = 1'b0;
        #1;
        test_reset();
        test_move();
        test_move_combo();
        test_select();
        test_clear();
        test_back_to_back_clr_sel();
        test_blink();
        test_rst_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/matrix_cursor_ctrl.md
Name: matrix_cursor_ctrl

Overview:
- Consumes the single-cycle press pulses from the per-button debounce filter stages: up, down, left, right, select, clear.
- Maintains a cursor position on the LED matrix and a blink signal for cursor display.
- Issues pixel write requests to the frame-buffer write port through a req/ack handshake: toggle the pixel under the cursor, or clear the whole frame.
- Sits between the button filters and the frame-buffer/scan logic.

Parameters:
ROWS, 8, matrix row count (>=2)
COLS, 8, matrix column count (>=2)
ROW_W, 3, row index width, ceil(log2(ROWS))
COL_W, 3, column index width, ceil(log2(COLS))
BLINK_DIV, 12500000, clk cycles per cursor_blink half-period (>=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
btn_up_p  in  1  one-cycle press pulse, move cursor up (row-1)
btn_dn_p  in  1  one-cycle press pulse, move cursor down (row+1)
btn_lt_p  in  1  one-cycle press pulse, move cursor left (col-1)
btn_rt_p  in  1  one-cycle press pulse, move cursor right (col+1)
btn_sel_p  in  1  one-cycle press pulse, toggle pixel at cursor
btn_clr_p  in  1  one-cycle press pulse, clear whole frame
pix_q  in  1  current frame-buffer value at (cur_row,cur_col), combinational read
wr_ack  in  1  frame buffer accepted current write
cur_row  out  ROW_W  cursor row
cur_col  out  COL_W  cursor column
cursor_blink  out  1  cursor visibility phase
wr_req  out  1  write request
wr_row  out  ROW_W  write row address
wr_col  out  COL_W  write column address
wr_data  out  1  write data
busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset values: cur_row=0, cur_col=0, wr_req=0, wr_row=0, wr_col=0, wr_data=0, busy=0, cursor_blink=1, blink counter=0, state=IDLE.
- States: IDLE, WRITE, CLEAR.
- IDLE event priority, evaluated per cycle:
  - btn_clr_p is highest.
  - then btn_sel_p.
  - then movement.
- Any pulse arriving while not in IDLE is dropped; there is no queueing.
- Movement (IDLE, no clr/sel):
  - Row and column update independently in the same cycle.
  - up and down together: row unchanged. left and right together: column unchanged.
  - Wrap-around: row 0 up -> ROWS-1; row ROWS-1 down -> 0. Columns wrap the same way.
  - The new position is visible on cur_row/cur_col the cycle after the pulse.
  - Any effective move resets the blink counter to 0 and sets cursor_blink=1.
- Select (IDLE):
  - Next cycle: state=WRITE, wr_req=1, wr_row=cur_row, wr_col=cur_col, wr_data=~pix_q sampled in the pulse cycle.
- WRITE:
  - wr_req, wr_row, wr_col and wr_data are held stable until a cycle with wr_req=1 && wr_ack=1.
  - Next cycle: wr_req=0, state=IDLE.
  - wr_ack while wr_req=0 is ignored.
- Clear (IDLE):
  - Next cycle: state=CLEAR, wr_req=1, address (0,0), wr_data=0.
  - Each accepted ack advances the address row-major (col+1, wrapping to the next row) with wr_req kept high and no bubble cycle.
  - After the ack at (ROWS-1,COLS-1): wr_req=0, state=IDLE, cur_row=0, cur_col=0, cursor_blink=1.
  - Exactly ROWS*COLS writes are issued.
- Blink:
  - The counter runs in every state.
  - At count BLINK_DIV-1 the counter wraps to 0 and cursor_blink toggles.
- busy is registered and equals (state != IDLE).
- rst mid-WRITE or mid-CLEAR aborts immediately: all reset values apply the following cycle and wr_req drops even if no ack was received.

Test Plan:
- Reset, then 3x btn_dn_p and 2x btn_lt_p -> cur_row=3, cur_col=6. cursor_blink=1 after each move.
- At (0,0), btn_up_p+btn_dn_p in the same cycle plus btn_lt_p -> row stays 0, col=7. Then btn_rt_p -> col=0 (wrap).
- At (2,5), pix_q=0, btn_sel_p; hold wr_ack=0 for 4 cycles, then 1 -> wr_req=1 with (2,5,1) stable for 5 cycles, drops the cycle after ack, busy=0. A btn_dn_p during the wait leaves the cursor unchanged.
- btn_clr_p with wr_ack tied high -> 64 consecutive writes with wr_data=0, addresses (0,0)..(7,7) row-major. busy high for 64 cycles. Cursor ends at (0,0).
- btn_clr_p and btn_sel_p in the same cycle -> CLEAR entered, no toggle write issued.
- BLINK_DIV=4, idle -> cursor_blink toggles every 4 cycles. Assert rst during CLEAR at address 10 -> wr_req=0, busy=0, cursor (0,0) the next cycle.
